// File: rtl/mux2_arb_pkg.sv
// Shared encodings for the two-requester arbiter: FSM states, select values
// and the hold-counter width helper.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Counter must be able to hold the value MAX_HOLD itself (saturation point).
  function automatic int hold_width(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/mux2_arb_pick.sv
// Combinational round-robin pick between two requesters; the requester that
// was not the last owner wins a tie.
module mux2_arb_pick
  import mux2_arb_pkg::*;
(
  input  logic reqA,
  input  logic reqB,
  input  logic last,
  output logic win,
  output logic valid
);

  always_comb begin
    valid = reqA | reqB;
    if (reqA && reqB) begin
      win = (last == SEL_A) ? SEL_B : SEL_A;
    end else if (reqB) begin
      win = SEL_B;
    end else begin
      win = SEL_A;
    end
  end

endmodule

// File: rtl/mux2_arb.sv
// Round-robin arbiter and select controller for a shared 2:1 mux path.
// Define MUX2_ARB_TIMEOUT_EN to build the contention hold-limit (timeout) logic.
module mux2_arb
  import mux2_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic reqA,
  input  logic reqB,
  input  logic doneA,
  input  logic doneB,
  output logic gntA,
  output logic gntB,
  output logic sel,
  output logic busy,
  output logic timeout
);

  state_t state;
  state_t state_next;
  logic   last;
  logic   to_fire;
  logic   release_now;
  logic   arb_en;
  logic   pick_a;
  logic   pick_b;
  logic   win;
  logic   valid;
  logic   entering;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam int CW = hold_width(MAX_HOLD);
  logic [CW-1:0] hold_cnt;

  always_comb begin
    to_fire = ((state == OWN_A && reqB) || (state == OWN_B && reqA)) &&
              (hold_cnt == CW'(MAX_HOLD - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (entering) begin
      hold_cnt <= '0;
    end else if (state != IDLE && hold_cnt != CW'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_HOLD < 2);
  assign to_fire    = 1'b0;
`endif

  // A revoked owner is masked out of the pick so the grant always moves on.
  always_comb begin
    release_now = 1'b0;
    case (state)
      OWN_A:   release_now = doneA | ~reqA | to_fire;
      OWN_B:   release_now = doneB | ~reqB | to_fire;
      IDLE:    release_now = 1'b0;
      default: release_now = 1'b1;
    endcase
    arb_en = (state == IDLE) | release_now;
    pick_a = reqA & ~(to_fire & (state == OWN_A));
    pick_b = reqB & ~(to_fire & (state == OWN_B));
  end

  mux2_arb_pick u_pick (
    .reqA  (pick_a),
    .reqB  (pick_b),
    .last  (last),
    .win   (win),
    .valid (valid)
  );

  always_comb begin
    entering   = arb_en & valid;
    state_next = state;
    if (arb_en) begin
      if (valid) begin
        state_next = (win == SEL_B) ? OWN_B : OWN_A;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gntA    <= 1'b0;
      gntB    <= 1'b0;
      sel     <= SEL_A;
      last    <= SEL_B;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      gntA    <= (state_next == OWN_A);
      gntB    <= (state_next == OWN_B);
      timeout <= to_fire;
      if (entering) begin
        sel  <= win;
        last <= win;
      end
    end
  end

  assign busy = gntA | gntB;

endmodule

// File: tb/tb_mux2_arb.sv
// Directed bench for mux2_arb: expected grant/select/timeout vectors are queued
// with each stimulus step and checked one clock edge later.
module tb_mux2_arb;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic reqA, reqB, doneA, doneB;
  logic gntA, gntB, sel, busy, timeout;

  typedef struct {
    string    tag;
    logic [4:0] vec;   // {gntA, gntB, sel, busy, timeout}
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mux2_arb #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .reqA    (reqA),
    .reqB    (reqB),
    .doneA   (doneA),
    .doneB   (doneB),
    .gntA    (gntA),
    .gntB    (gntB),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic ea, input logic eb,
                          input logic es, input logic et);
    exp_t e;
    e.tag = tag;
    e.vec = {ea, eb, es, ea | eb, et};
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    logic [4:0] obs;
    obs = {gntA, gntB, sel, busy, timeout};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty obs=%b exp=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.vec) else begin
        errors++;
        $error("FAIL %s obs={gA,gB,sel,busy,to}=%b exp=%b", e.tag, obs, e.vec);
      end
      $display("check %-18s obs=%b exp=%b", e.tag, obs, e.vec);
    end
  endtask

  task automatic expect_edge(input string tag, input logic ea, input logic eb,
                             input logic es, input logic et);
    push_exp(tag, ea, eb, es, et);
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic step(input logic ra, input logic rb, input logic da, input logic db,
                      input string tag, input logic ea, input logic eb,
                      input logic es, input logic et);
    @(negedge clk);
    reqA = ra; reqB = rb; doneA = da; doneB = db;
    expect_edge(tag, ea, eb, es, et);
  endtask

  initial begin
    rst = 1'b1;
    reqA = 1'b1; reqB = 1'b1; doneA = 1'b0; doneB = 1'b0;
    #3;
    push_exp("reset", 0, 0, 0, 0);
    check_now();

    // Both requesting out of reset: A wins the first contention.
    @(negedge clk);
    rst = 1'b0;
    expect_edge("first_grant", 1, 0, 0, 0);
    step(1, 1, 0, 0, "hold_a",        1, 0, 0, 0);
    step(1, 1, 1, 0, "handoff_b",     0, 1, 1, 0);

    // Alternation with done on the second cycle of every grant.
    step(1, 1, 0, 0, "alt_b2",        0, 1, 1, 0);
    step(1, 1, 0, 1, "alt_to_a",      1, 0, 0, 0);
    step(1, 1, 0, 0, "alt_a2",        1, 0, 0, 0);
    step(1, 1, 1, 0, "alt_to_b",      0, 1, 1, 0);
    step(1, 1, 0, 0, "alt_b2_again",  0, 1, 1, 0);
    step(1, 1, 0, 1, "alt_to_a2",     1, 0, 0, 0);
    step(1, 1, 0, 1, "ignore_done_b", 1, 0, 0, 0);

    // A drops its request; B alone is re-granted across its done pulses.
    step(0, 1, 0, 0, "a_drop_b",      0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, "b_only_hold",  0, 1, 1, 0);
      step(0, 1, 0, 0, "b_only_hold2", 0, 1, 1, 0);
      step(0, 1, 0, 1, "b_regrant",    0, 1, 1, 0);
    end
    step(0, 1, 1, 0, "ignore_done_a", 0, 1, 1, 0);
    step(0, 0, 0, 0, "idle_sel_hold", 0, 0, 1, 0);

    // Contention with no done from A: revoked after 4 cycles only with timeout built.
    step(1, 0, 0, 0, "to_grant_a",    1, 0, 0, 0);
    step(1, 1, 0, 0, "to_hold2",      1, 0, 0, 0);
    step(1, 1, 0, 0, "to_hold3",      1, 0, 0, 0);
    step(1, 1, 0, 0, "to_hold4",      1, 0, 0, 0);
    step(1, 1, 0, 0, "to_edge",       !TO_EN, TO_EN, TO_EN, TO_EN);
    step(1, 1, 0, 0, "to_after",      !TO_EN, TO_EN, TO_EN, 1'b0);
    step(1, 1, 1, 0, "reach_own_b",   0, 1, 1, 0);

    // Asynchronous reset in the middle of an OWN_B cycle.
    #2;
    rst = 1'b1;
    #1;
    push_exp("async_rst", 0, 0, 0, 0);
    check_now();
    @(negedge clk);
    rst = 1'b0;
    expect_edge("post_rst_a_wins", 1, 0, 0, 0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain obs=%0d exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_arb.md
# mux2_arb

Two-requester round-robin arbiter and select controller for the 2:1 mux datapath. It owns the select line of a `mux2_1`-based shared path. It grants the path to requester A or B with a fair alternation policy and holds the grant until the owner signals completion. It sits between two producers and any single-ported consumer built from the mux primitives.

## Interface
- `MAX_HOLD`, 8: maximum granted cycles under contention; legal range ≥2. Used only with the timeout feature.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `reqA` input 1: requester A wants the path; level, held until served.
- `reqB` input 1: requester B wants the path.
- `doneA` input 1: A releases the path. Sampled only while `gntA`=1.
- `doneB` input 1: B releases the path. Sampled only while `gntB`=1.
- `gntA` output 1: registered grant to A.
- `gntB` output 1: registered grant to B.
- `sel` output 1: registered mux select. 0 selects A, 1 selects B. Drives the mux `S` input.
- `busy` output 1: `gntA | gntB`.
- `timeout` output 1: one-cycle pulse when a grant is forcibly revoked. Constant 0 when the timeout feature is compiled out.

## Operation
- FSM has three states: IDLE, OWN_A, OWN_B.
  - `gntA` = (state==OWN_A).
  - `gntB` = (state==OWN_B).
- A `last` flag records the most recent owner; 0 = A, 1 = B.
- Arbitration is evaluated in IDLE, or on the release edge of a grant:
  - only A requests → OWN_A;
  - only B requests → OWN_B;
  - both request → the requester that is not `last`;
  - neither requests → IDLE.
- In OWN_X, the grant is released when `doneX`=1 or `reqX`=0. Arbitration then runs in the same cycle with `last`=X.
  - Handoff to the other requester therefore has zero bubble.
  - If only X is still requesting, X is re-granted.
- `sel` updates only on entry to OWN_A (→0) or OWN_B (→1). In IDLE it holds the last owner's value.
- `last` updates on entry to OWN_A or OWN_B.
- `doneA` and `doneB` are ignored when the corresponding grant is not held.
- `gntA` and `gntB` are never both 1.
- Reset values: state IDLE, `gntA`=0, `gntB`=0, `busy`=0, `sel`=0, `timeout`=0, `last`=1 (A wins the first contention), hold counter 0.
- Reset asserted mid-grant returns all outputs to their reset values immediately, with no wait for a clock edge.

## Timing
- Request to grant latency is 1 cycle. A `req` sampled high at edge k in IDLE gives the grant visible after edge k.
- Release: `done` sampled at edge k drops the grant after edge k. The next owner's grant rises at the same edge k.
- A `sel` change is coincident with the grant change. The mux output reflects the new owner in the first granted cycle.
- A simultaneous `doneX` and `reqY` at one edge hands off to Y at that edge.

## Configuration
- `MUX2_ARB_TIMEOUT_EN` defined:
  - A hold counter of width clog2(MAX_HOLD+1) clears on every grant entry, increments each granted cycle, and saturates.
  - When the counter equals MAX_HOLD−1 and the other requester is requesting, the grant transfers at the next edge and `timeout` pulses for 1 cycle.
  - Without contention the owner is never revoked.
- `MUX2_ARB_TIMEOUT_EN` undefined:
  - No counter is built and `timeout` is tied to 0.
  - A grant is held until `done` or until the owner's `req` deasserts.

## Structure
- A shared package/include `mux2_arb_pkg` holds:
  - the state encodings IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10;
  - the select constants SEL_A=1'b0 and SEL_B=1'b1.
- One sub-module, `mux2_arb_pick`, is combinational. It takes (`reqA`, `reqB`, `last`) and returns the winner and a valid flag. It is reused by both the IDLE path and the release path.
- State, `sel`, `last` and the counter live in the top module as flops with asynchronous reset.

## Test plan
- Reset with `reqA`=1 and `reqB`=1 held, then `rst` deasserted → A is granted at the first edge, `sel`=0, `gntB`=0.
- A granted, `doneA`=1 for one cycle with `reqB`=1 → at that edge `gntA`=0, `gntB`=1 and `sel`=1, with no idle cycle.
- `reqB` only, with `doneB` pulsed every 3 cycles and `reqB` held → B is re-granted continuously, `sel` stays 1, and `busy` never drops.
- Both requests held, with `doneA`/`doneB` asserted on the second cycle of each grant → grants alternate A, B, A, B, each lasting exactly 2 cycles.
- With `MUX2_ARB_TIMEOUT_EN` and MAX_HOLD=4: A granted, no `doneA`, `reqB`=1 → A holds exactly 4 cycles, then `gntB`=1 and `timeout` is 1 for one cycle. Without the macro, A holds indefinitely and `timeout` stays 0.
- `rst` asserted asynchronously mid-OWN_B → `gntB`, `busy` and `sel` go to 0 before the next clock edge; after release A wins the next contention.
